// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IR opcodes, capture value and the decoded instruction type.
package jtag_pkg;

  localparam logic [3:0] OP_LOAD_PROGRAM = 4'b0001;
  localparam logic [3:0] OP_SCAN_TEST    = 4'b0010;
  localparam logic [3:0] OP_BYPASS       = 4'b0011;
  localparam logic [3:0] IR_CAPTURE      = 4'b0001;

  typedef enum logic [1:0] {
    INSTR_BYPASS       = 2'd0,
    INSTR_LOAD_PROGRAM = 2'd1,
    INSTR_SCAN_TEST    = 2'd2
  } instr_e;

  // Unknown opcodes fall back to BYPASS so TDO always has a defined path.
  function automatic instr_e decode_ir(input logic [3:0] op);
    instr_e res;
    case (op)
      OP_LOAD_PROGRAM: res = INSTR_LOAD_PROGRAM;
      OP_SCAN_TEST:    res = INSTR_SCAN_TEST;
      OP_BYPASS:       res = INSTR_BYPASS;
      default:         res = INSTR_BYPASS;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/jtag_word_writer.sv
// Holds one received program word and presents it to instruction memory until accepted,
// then advances the word address.
module jtag_word_writer
  import jtag_pkg::*;
#(
  parameter int DR_WIDTH   = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  tck_i,
  input  logic                  rst_i,
  input  logic                  wordValid_i,
  input  logic [DR_WIDTH-1:0]   word_i,
  input  logic                  addrClr_i,
  input  logic                  memReady_i,
  output logic                  memWrEn_o,
  output logic [ADDR_WIDTH-1:0] memAddr_o,
  output logic [DR_WIDTH-1:0]   memData_o
);

  logic                  wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DR_WIDTH-1:0]   data_q, data_d;
  logic                  clrPend_q, clrPend_d;

  // An address clear arriving mid-write is deferred so the address stays stable until accepted.
  always_comb begin
    wrEn_d    = wrEn_q;
    addr_d    = addr_q;
    data_d    = data_q;
    clrPend_d = clrPend_q;
    if (wrEn_q) begin
      if (memReady_i) begin
        wrEn_d    = 1'b0;
        clrPend_d = 1'b0;
        if (clrPend_q || addrClr_i) begin
          addr_d = '0;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end else begin
        if (addrClr_i) begin
          clrPend_d = 1'b1;
        end else begin
          clrPend_d = clrPend_q;
        end
      end
    end else begin
      if (addrClr_i) begin
        addr_d = '0;
      end else begin
        addr_d = addr_q;
      end
      if (wordValid_i) begin
        wrEn_d = 1'b1;
        data_d = word_i;
      end else begin
        data_d = data_q;
      end
    end
  end

  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      wrEn_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      clrPend_q <= 1'b0;
    end else begin
      wrEn_q    <= wrEn_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      clrPend_q <= clrPend_d;
    end
  end

  assign memWrEn_o = wrEn_q;
  assign memAddr_o = addr_q;
  assign memData_o = data_q;

endmodule

// File: rtl/jtag_program_loader.sv
// JTAG IR/DR registers and TDO mux; LOAD_PROGRAM streams 32-bit words into instruction memory.
module jtag_program_loader
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH   = 4,
  parameter int                  DR_WIDTH   = 32,
  parameter int                  ADDR_WIDTH = 10,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = jtag_pkg::IR_CAPTURE
) (
  input  logic                  tck_i,
  input  logic                  rst_i,
  input  logic                  tdi_i,
  input  logic                  shiftIR_i,
  input  logic                  updateIR_i,
  input  logic                  shiftDR_i,
  input  logic                  updateDR_i,
  input  logic                  SelectIR_i,
  output logic                  tdo_o,
  output logic                  scanEn_o,
  output logic                  scanIn_o,
  input  logic                  scanOut_i,
  output logic                  memWrEn_o,
  output logic [ADDR_WIDTH-1:0] memAddr_o,
  output logic [DR_WIDTH-1:0]   memData_o,
  input  logic                  memReady_i,
  output logic                  loadActive_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(DR_WIDTH + 2);

  logic [IR_WIDTH-1:0] irShift_q, irShift_d;
  logic [IR_WIDTH-1:0] irReg_q, irReg_d;
  logic [DR_WIDTH-1:0] wordShift_q, wordShift_d;
  logic [CNT_W-1:0]    bitCnt_q, bitCnt_d;
  logic                bypass_q, bypass_d;
  logic                err_q, err_d;
  logic                wordValid_s;
  logic                addrClr_s;
  instr_e              instr_s;

  assign instr_s = decode_ir(irReg_q);

  // IR path; update wins over a simultaneous shift.
  always_comb begin
    irShift_d = irShift_q;
    irReg_d   = irReg_q;
    addrClr_s = 1'b0;
    if (updateIR_i) begin
      irReg_d   = irShift_q;
      irShift_d = IR_CAPTURE;
      addrClr_s = (decode_ir(irShift_q) == INSTR_LOAD_PROGRAM);
    end else if (shiftIR_i) begin
      irShift_d = {tdi_i, irShift_q[IR_WIDTH-1:1]};
    end else begin
      irShift_d = irShift_q;
    end
  end

  always_comb begin
    wordShift_d = wordShift_q;
    bitCnt_d    = bitCnt_q;
    bypass_d    = bypass_q;
    err_d       = err_q;
    wordValid_s = 1'b0;
    if (updateDR_i) begin
      bitCnt_d = '0;
      bypass_d = 1'b0;
      if (instr_s == INSTR_LOAD_PROGRAM) begin
        if ((bitCnt_q == CNT_W'(DR_WIDTH)) && !memWrEn_o) begin
          wordValid_s = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        err_d = err_q;
      end
    end else if (shiftDR_i) begin
      case (instr_s)
        INSTR_LOAD_PROGRAM: begin
          wordShift_d = {tdi_i, wordShift_q[DR_WIDTH-1:1]};
          if (bitCnt_q != CNT_W'(DR_WIDTH + 1)) begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end else begin
            bitCnt_d = bitCnt_q;
          end
        end
        INSTR_BYPASS: bypass_d = tdi_i;
        default:      bypass_d = bypass_q;
      endcase
    end else begin
      bitCnt_d = bitCnt_q;
    end
  end

  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      irShift_q   <= IR_CAPTURE;
      irReg_q     <= IR_WIDTH'(OP_BYPASS);
      wordShift_q <= '0;
      bitCnt_q    <= '0;
      bypass_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      irShift_q   <= irShift_d;
      irReg_q     <= irReg_d;
      wordShift_q <= wordShift_d;
      bitCnt_q    <= bitCnt_d;
      bypass_q    <= bypass_d;
      err_q       <= err_d;
    end
  end

  jtag_word_writer #(
    .DR_WIDTH   (DR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_writer (
    .tck_i       (tck_i),
    .rst_i       (rst_i),
    .wordValid_i (wordValid_s),
    .word_i      (wordShift_q),
    .addrClr_i   (addrClr_s),
    .memReady_i  (memReady_i),
    .memWrEn_o   (memWrEn_o),
    .memAddr_o   (memAddr_o),
    .memData_o   (memData_o)
  );

  always_comb begin
    tdo_o = 1'b0;
    if (SelectIR_i) begin
      tdo_o = irShift_q[0];
    end else begin
      case (instr_s)
        INSTR_LOAD_PROGRAM: tdo_o = wordShift_q[0];
        INSTR_SCAN_TEST:    tdo_o = scanOut_i;
        INSTR_BYPASS:       tdo_o = bypass_q;
        default:            tdo_o = bypass_q;
      endcase
    end
  end

  assign scanEn_o     = (instr_s == INSTR_SCAN_TEST) && shiftDR_i && !updateDR_i;
  assign scanIn_o     = tdi_i;
  assign loadActive_o = (instr_s == INSTR_LOAD_PROGRAM);
  assign err_o        = err_q;

endmodule
